// File: rtl/line_shift_buffer_ntap.sv
// Multi-line shift buffer: presents the same-column pixels of TAPS previous lines
// alongside the current pixel, with frame-aware per-tap validity and overflow tracking.

module line_shift_buffer_ntap_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module line_shift_buffer_ntap #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int TAPS   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic                   clken,
  input  logic [DATA_W-1:0]      shiftin,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_cur,
  output logic [TAPS*DATA_W-1:0] taps,
  output logic [TAPS-1:0]        tap_valid,
  output logic [ADDR_W:0]        line_len,
  output logic                   overflow
);
  localparam int LF_W = $clog2(TAPS + 1);

  logic [ADDR_W:0]                col;
  logic                           href_d;
  logic                           armed;
  logic [LF_W-1:0]                lines_filled;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              pix_d;
  logic [1:0]                     vld_pipe;
  logic [TAPS-1:0][DATA_W-1:0]    rd_data;
  logic [TAPS-1:0][DATA_W-1:0]    wr_data;
  logic [TAPS-1:0][DATA_W-1:0]    taps_q;
  logic [TAPS-1:0]                tv_next;
  logic                           accept;
  logic                           wr_acc;
  logic                           line_end;

  // col saturates at 2^ADDR_W, so its MSB alone flags a full line
  assign accept   = per_frame_href & clken & armed;
  assign wr_acc   = accept & ~col[ADDR_W];
  assign line_end = href_d & ~per_frame_href & (col != '0);
  assign out_valid = vld_pipe[1];
  assign taps      = taps_q;

  // RAM k is written with what RAM k-1 held at that column: a per-column line cascade
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    if (k == 0) begin : g_first
      assign wr_data[k] = pix_d;
    end else begin : g_next
      assign wr_data[k] = rd_data[k-1];
    end
    assign tv_next[k] = (lines_filled > LF_W'(k));

    line_shift_buffer_ntap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clock (clock),
      .re    (wr_acc),
      .raddr (col[ADDR_W-1:0]),
      .we    (vld_pipe[0] & ~reset),
      .waddr (wr_addr),
      .wdata (wr_data[k]),
      .rdata (rd_data[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col          <= '0;
      href_d       <= 1'b0;
      armed        <= 1'b0;
      lines_filled <= '0;
      wr_addr      <= '0;
      pix_d        <= '0;
      vld_pipe     <= '0;
      out_cur      <= '0;
      taps_q       <= '0;
      tap_valid    <= '0;
      line_len     <= '0;
      overflow     <= 1'b0;
    end else begin
      href_d   <= per_frame_href;
      vld_pipe <= {vld_pipe[0], wr_acc};
      // after a reset the current line is abandoned until href is seen low
      if (!per_frame_href) armed <= 1'b1;

      if (!per_frame_href)  col <= '0;
      else if (wr_acc)      col <= col + 1'b1;

      if (line_end) line_len <= col;

      if (per_frame_vsync) begin
        lines_filled <= '0;
        overflow     <= 1'b0;
      end else begin
        if (line_end && lines_filled != LF_W'(TAPS)) lines_filled <= lines_filled + 1'b1;
        if (accept && col[ADDR_W]) overflow <= 1'b1;
      end

      if (wr_acc) begin
        wr_addr <= col[ADDR_W-1:0];
        pix_d   <= shiftin;
      end

      if (vld_pipe[0]) begin
        out_cur   <= pix_d;
        taps_q    <= rd_data;
        tap_valid <= tv_next;
      end
    end
  end
endmodule

// File: tb/tb_line_shift_buffer_ntap.sv
// Scoreboard bench: instance A (8b, 8 columns, 2 taps) against a per-column
// cascade model; instance B (10b, 4 taps) against closed-form line data.

module tb_line_shift_buffer_ntap;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_run = 0;
  int n_fail = 0;

  // instance A
  logic        a_reset, a_vsync, a_href, a_clken;
  logic [7:0]  a_shiftin, a_out_cur;
  logic        a_out_valid, a_overflow;
  logic [15:0] a_taps;
  logic [1:0]  a_tap_valid;
  logic [3:0]  a_line_len;

  line_shift_buffer_ntap #(.DATA_W(8), .ADDR_W(3), .TAPS(2)) dut_a (
    .clock(clock), .reset(a_reset), .per_frame_vsync(a_vsync), .per_frame_href(a_href),
    .clken(a_clken), .shiftin(a_shiftin), .out_valid(a_out_valid), .out_cur(a_out_cur),
    .taps(a_taps), .tap_valid(a_tap_valid), .line_len(a_line_len), .overflow(a_overflow)
  );

  // instance B
  logic        b_reset, b_vsync, b_href, b_clken;
  logic [9:0]  b_shiftin, b_out_cur;
  logic        b_out_valid, b_overflow;
  logic [39:0] b_taps;
  logic [3:0]  b_tap_valid;
  logic [3:0]  b_line_len;

  line_shift_buffer_ntap #(.DATA_W(10), .ADDR_W(3), .TAPS(4)) dut_b (
    .clock(clock), .reset(b_reset), .per_frame_vsync(b_vsync), .per_frame_href(b_href),
    .clken(b_clken), .shiftin(b_shiftin), .out_valid(b_out_valid), .out_cur(b_out_cur),
    .taps(b_taps), .tap_valid(b_tap_valid), .line_len(b_line_len), .overflow(b_overflow)
  );

  typedef struct {
    logic [7:0]      cur;
    logic [1:0][7:0] tp;
    logic [1:0]      kn;
    logic [1:0]      tv;
  } exp_a_t;

  typedef struct {
    logic [9:0]      cur;
    logic [3:0][9:0] tp;
    logic [3:0]      tv;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  // model of instance A
  logic [7:0] m_ram [2][8];
  bit         m_kn  [2][8];
  int         m_col = 0;
  int         m_lf = 0;
  bit         m_armed = 0, m_href_d = 0, m_pend = 0;
  int         m_pc = 0;
  logic [7:0] m_pd;
  logic [1:0] vh = 2'b00;
  bit         mon_en = 0;
  int         b_cnt = 0;

  task automatic step(input logic h, input logic ce, input logic vs, input logic rst,
                      input logic [7:0] d);
    exp_a_t e;
    bit acc, wr, fall;
    if (m_pend && !rst) begin
      m_ram[1][m_pc] = m_ram[0][m_pc];
      m_kn[1][m_pc]  = m_kn[0][m_pc];
      m_ram[0][m_pc] = m_pd;
      m_kn[0][m_pc]  = 1'b1;
    end
    m_pend = 0;
    a_href = h; a_clken = ce; a_vsync = vs; a_reset = rst; a_shiftin = d;
    wr = 0;
    if (rst) begin
      m_col = 0; m_lf = 0; m_armed = 0; m_href_d = 0;
    end else begin
      acc  = h && ce && m_armed;
      wr   = acc && (m_col < 8);
      fall = m_href_d && !h;
      if (fall && m_col != 0 && m_lf < 2) m_lf++;
      if (vs) m_lf = 0;
      if (wr) begin
        e.cur = d;
        e.tv  = {m_lf > 1, m_lf > 0};
        for (int k = 0; k < 2; k++) begin
          e.tp[k] = m_ram[k][m_col];
          e.kn[k] = m_kn[k][m_col];
        end
        qa.push_back(e);
        m_pend = 1; m_pc = m_col; m_pd = d;
      end
      if (!h) begin m_col = 0; m_armed = 1; end
      else if (wr) m_col++;
      m_href_d = h;
    end
    @(posedge clock);
    #1;
    vh = rst ? 2'b00 : {vh[0], wr};
    if (rst) qa.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
  endtask

  task automatic line_a(input int len, input logic [7:0] base);
    for (int c = 0; c < len; c++) step(1, 1, 0, 0, base + 8'(c));
    idle(2);
  endtask

  always @(negedge clock) begin
    exp_a_t e;
    if (mon_en) begin
      n_run++;
      if (a_out_valid !== vh[1]) begin
        n_fail++;
        $display("FAIL a_out_valid got %b want %b at %0t", a_out_valid, vh[1], $time);
      end
      if (a_out_valid === 1'b1) begin
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_output cur %h at %0t", a_out_cur, $time);
        end else begin
          e = qa.pop_front();
          n_run += 2;
          if (a_out_cur !== e.cur) begin
            n_fail++;
            $display("FAIL a_out_cur got %h want %h at %0t", a_out_cur, e.cur, $time);
          end
          if (a_tap_valid !== e.tv) begin
            n_fail++;
            $display("FAIL a_tap_valid got %b want %b at %0t", a_tap_valid, e.tv, $time);
          end
          for (int k = 0; k < 2; k++) if (e.kn[k]) begin
            n_run++;
            if (a_taps[k*8 +: 8] !== e.tp[k]) begin
              n_fail++;
              $display("FAIL a_taps[%0d] got %h want %h at %0t", k, a_taps[k*8 +: 8], e.tp[k], $time);
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    exp_b_t e;
    if (b_out_valid === 1'b1) begin
      b_cnt++;
      n_run++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_output cur %h at %0t", b_out_cur, $time);
      end else begin
        e = qb.pop_front();
        if (b_out_cur !== e.cur || b_tap_valid !== e.tv) begin
          n_fail++;
          $display("FAIL b_cur_tv got %h/%b want %h/%b at %0t", b_out_cur, b_tap_valid, e.cur, e.tv, $time);
        end
        for (int k = 0; k < 4; k++) if (e.tv[k]) begin
          n_run++;
          if (b_taps[k*10 +: 10] !== e.tp[k]) begin
            n_fail++;
            $display("FAIL b_taps[%0d] got %h want %h at %0t", k, b_taps[k*10 +: 10], e.tp[k], $time);
          end
        end
      end
    end
  end

  task automatic test_reset;
    b_reset = 1; b_vsync = 0; b_href = 0; b_clken = 0; b_shiftin = '0;
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    b_reset = 0;
    n_run++;
    if ({a_out_valid, a_out_cur, a_taps, a_tap_valid, a_line_len, a_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_a got v%b c%h t%h tv%b l%0d o%b want all 0",
               a_out_valid, a_out_cur, a_taps, a_tap_valid, a_line_len, a_overflow);
    end
    n_run++;
    if ({b_out_valid, b_out_cur, b_taps, b_tap_valid, b_line_len, b_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_b got v%b c%h t%h tv%b want all 0", b_out_valid, b_out_cur, b_taps, b_tap_valid);
    end
    mon_en = 1;
  endtask

  task automatic test_three_lines;
    step(0, 0, 1, 0, 8'h00);
    idle(1);
    for (int l = 0; l < 3; l++) line_a(4, 8'(l * 16));
    n_run++;
    if (a_line_len !== 4'd4 || a_tap_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL three_lines len/tv got %0d/%b want 4/11", a_line_len, a_tap_valid);
    end
  endtask

  task automatic test_clken_gaps;
    for (int i = 0; i < 8; i++) step(1, 1'(~i[0]), 0, 0, 8'h40 + 8'(i));
    idle(2);
    n_run++;
    if (a_line_len !== 4'd4) begin
      n_fail++;
      $display("FAIL clken_gaps line_len got %0d want 4", a_line_len);
    end
  endtask

  task automatic test_overflow;
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 8'h50 + 8'(i));
      if (i == 7 || i == 8) begin
        n_run++;
        if (a_overflow !== (i == 8)) begin
          n_fail++;
          $display("FAIL overflow_at_%0d got %b want %b", i, a_overflow, i == 8);
        end
      end
    end
    idle(2);
    n_run++;
    if (a_line_len !== 4'd8 || a_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_line len/ovf got %0d/%b want 8/1", a_line_len, a_overflow);
    end
    step(0, 0, 1, 0, 8'h00);
    n_run++;
    if (a_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear got %b want 0", a_overflow);
    end
  endtask

  task automatic test_line_len;
    step(0, 0, 1, 0, 8'h00);
    line_a(5, 8'h60);
    n_run++;
    if (a_line_len !== 4'd5) begin
      n_fail++;
      $display("FAIL line_len_5 got %0d want 5", a_line_len);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'hEE);
    idle(2);
    n_run++;
    if (a_line_len !== 4'd5) begin
      n_fail++;
      $display("FAIL line_len_empty got %0d want 5", a_line_len);
    end
    line_a(3, 8'h70);
    n_run++;
    if (a_line_len !== 4'd3 || a_tap_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL line_len_3 len/tv got %0d/%b want 3/01", a_line_len, a_tap_valid);
    end
  endtask

  task automatic test_reset_midline;
    step(0, 0, 1, 0, 8'h00);
    line_a(4, 8'h80);
    line_a(4, 8'h90);
    step(1, 1, 0, 0, 8'hA0);
    step(1, 1, 0, 0, 8'hA1);
    step(1, 1, 0, 1, 8'hA2);
    n_run++;
    if ({a_out_valid, a_out_cur, a_taps, a_tap_valid, a_line_len, a_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_midline got v%b c%h t%h tv%b l%0d o%b want all 0",
               a_out_valid, a_out_cur, a_taps, a_tap_valid, a_line_len, a_overflow);
    end
    step(1, 1, 0, 0, 8'hA3);
    step(1, 1, 0, 0, 8'hA4);
    idle(2);
    line_a(4, 8'hB0);
    n_run++;
    if (a_tap_valid !== 2'b00 || a_line_len !== 4'd4) begin
      n_fail++;
      $display("FAIL after_reset tv/len got %b/%0d want 00/4", a_tap_valid, a_line_len);
    end
  endtask

  task automatic test_taps4;
    exp_b_t e;
    @(posedge clock); #1;
    b_vsync = 1;
    @(posedge clock); #1;
    b_vsync = 0;
    for (int l = 0; l < 6; l++) begin
      for (int c = 0; c < 3; c++) begin
        b_href = 1; b_clken = 1; b_shiftin = 10'(l * 64 + c);
        e.cur = b_shiftin;
        for (int k = 0; k < 4; k++) begin
          e.tv[k] = (l > k);
          e.tp[k] = (l > k) ? 10'((l - 1 - k) * 64 + c) : 10'h0;
        end
        qb.push_back(e);
        @(posedge clock); #1;
      end
      b_href = 0; b_clken = 0;
      repeat (2) begin @(posedge clock); #1; end
    end
    n_run++;
    if (b_tap_valid !== 4'b1111 || b_taps[30 +: 10] !== 10'(64 + 2) || b_line_len !== 4'd3) begin
      n_fail++;
      $display("FAIL taps4_final tv/tap3/len got %b/%h/%0d want 1111/042/3",
               b_tap_valid, b_taps[30 +: 10], b_line_len);
    end
  endtask

  initial begin
    a_reset = 1; a_vsync = 0; a_href = 0; a_clken = 0; a_shiftin = '0;
    b_reset = 1; b_vsync = 0; b_href = 0; b_clken = 0; b_shiftin = '0;
    test_reset();
    test_three_lines();
    test_clken_gaps();
    test_overflow();
    test_line_len();
    test_reset_midline();
    idle(3);
    test_taps4();
    idle(3);
    n_run++;
    if (qa.size() != 0 || qb.size() != 0 || b_cnt != 18) begin
      n_fail++;
      $display("FAIL drain qa %0d qb %0d b_outputs %0d want 0 0 18", qa.size(), qb.size(), b_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/line_shift_buffer_ntap.md
# line_shift_buffer_ntap

Parametrised multi-line shift buffer for the matrix-generate stage of the video pipeline. Accepts one pixel per enabled cycle inside `per_frame_href` and presents the same-column pixels of the TAPS previous lines alongside the current pixel, so downstream 3x3 / 5x5 window generators can build their matrix. Compared with the fixed 8-bit two-line buffer, it adds configurable width, depth and tap count, frame-aware fill tracking, per-tap validity, line-length capture and overflow detection.

## Interface
- DATA_W, 8, pixel width in bits
- ADDR_W, 10, column address width; max line length 2^ADDR_W pixels
- TAPS, 2, number of previous lines buffered (1..8)
- clock  in  1  sole clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- per_frame_vsync  in  1  frame sync; high = between frames
- per_frame_href  in  1  line active
- clken  in  1  pixel qualifier; pixel accepted when `per_frame_href & clken`
- shiftin  in  DATA_W  input pixel
- out_valid  out  1  output pixel valid strobe
- out_cur  out  DATA_W  current pixel, delayed to align with taps
- taps  out  TAPS*DATA_W  slice k (bits k*DATA_W +: DATA_W) = pixel from k+1 lines earlier, same column
- tap_valid  out  TAPS  bit k high when slice k holds real data from this frame
- line_len  out  ADDR_W+1  pixel count of last completed line
- overflow  out  1  sticky; line exceeded 2^ADDR_W pixels

## Operation
- Column counter `col` (ADDR_W+1 bits): cleared when href low; increments on each accepted pixel.
- Storage: TAPS simple dual-port RAMs, depth 2^ADDR_W, DATA_W wide. On accepted pixel at column c: read all RAMs at c; one cycle later write RAM0 <= delayed shiftin, RAM k <= value read from RAM k-1 at c (cascade). Writes never target the column being read in the same cycle.
- Overflow: accepted pixel with col == 2^ADDR_W is not written and produces no out_valid; overflow set, held until vsync high or reset.
- Line end: href falling edge with col > 0 -> line_len <= col (saturated at 2^ADDR_W); lines_filled increments, saturating at TAPS. href falling with col == 0 -> no change.
- Frame start: while per_frame_vsync high, lines_filled <= 0, overflow <= 0; RAM contents untouched (stale data masked by tap_valid).
- tap_valid[k] = (lines_filled > k), registered with the output data.
- Taps for column c where the previous line was shorter than c: RAM contents returned as-is, tap_valid unchanged (no per-column masking).

## Timing
- Latency: pixel accepted in cycle t -> out_valid high in cycle t+2 with out_cur = that pixel and taps aligned; one out_valid per accepted pixel, gaps in clken preserved.
- Back-to-back acceptance at full rate supported; no stall output.
- Reset: out_valid=0, out_cur=0, taps=0, tap_valid=0, line_len=0, overflow=0, col=0, lines_filled=0; pipeline flushed (in-flight pixels dropped, no pending writes). Reset mid-line: subsequent pixels treated as column 0 only after href next goes low then high.
- vsync and href high simultaneously: vsync clears take priority; pixel still accepted and output.
- href falling and a pixel accepted in the same cycle impossible (acceptance requires href high); final pixel of line still emerges at t+2 after href fell.

## Test plan
- DATA_W=8, TAPS=2, three lines of 4 pixels values L*16+c after vsync -> line 0 outputs tap_valid=00; line 1 taps[0]=0x00..0x03, tap_valid=01; line 2 taps[0]=0x10..0x13, taps[1]=0x00..0x03, tap_valid=11.
- clken toggling 1,0,1,0 on a line -> out_valid pattern identical, delayed exactly 2 cycles; tap data matches column, not cycle.
- ADDR_W=3, line of 10 pixels -> 8 outputs, overflow=1 from the 9th accept, line_len=8; vsync pulse clears overflow to 0.
- Lines of 5 then 3 pixels -> line_len 5 then 3; href high with no clken -> line_len and lines_filled unchanged.
- Reset asserted mid-line at column 2 of line 2 -> all outputs 0 next cycle, tap_valid=00 on the following line.
- TAPS=4, DATA_W=10, six lines -> tap_valid progresses 0000,0001,0011,0111,1111,1111; taps[3] on line 5 equals line 1 data.
